// File: rtl/ps2_key_rollover.sv
// ps2_key_rollover: PS/2 scan-code decoder tracking up to four simultaneously held keys.
// Define PS2_ROLLOVER_TIMEOUT_EN to flush stale keys after TIMEOUT_CYCLES idle clock cycles.
module ps2_key_rollover #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    output logic [31:0] PS2keycode,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    state_e          state_q, state_d;
    logic [3:0][7:0] slots_q, slots_d;
    logic            overflow_q, overflow_d;

    logic            held;
    logic            free_found;
    logic [1:0]      free_idx;
    logic            ignored;

    if (TIMEOUT_CYCLES == 32'd0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

`ifdef PS2_ROLLOVER_TIMEOUT_EN
    logic [31:0] idle_cnt_q;
    logic        expire;

    assign expire = (idle_cnt_q == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge Clk) begin
        if (Reset || scan_valid || expire) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
        end
    end
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        slots_d    = slots_q;
        overflow_d = 1'b0;

        held = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (slots_q[i] == scan_code) held = 1'b1;
        end

        // Scan downwards so the lowest-numbered empty slot wins.
        free_found = 1'b0;
        free_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slots_q[i] == 8'h00) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
        end

        case (scan_code)
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF, 8'hE1: ignored = 1'b1;
            default:                                  ignored = 1'b0;
        endcase

        if (scan_valid) begin
            if (scan_code == CODE_EXT) begin
                state_d = (state_q == IDLE || state_q == EXT) ? EXT : EXT_BRK;
            end else if (scan_code == CODE_BRK) begin
                state_d = (state_q == IDLE) ? BRK : EXT_BRK;
            end else if (state_q == BRK || state_q == EXT_BRK) begin
                for (int i = 0; i < 4; i++) begin
                    if (slots_q[i] == scan_code) slots_d[i] = 8'h00;
                end
                state_d = IDLE;
            end else if (!ignored) begin
                if (!held) begin
                    if (free_found) slots_d[free_idx] = scan_code;
                    else            overflow_d        = 1'b1;
                end
                state_d = IDLE;
            end
        end
`ifdef PS2_ROLLOVER_TIMEOUT_EN
        else if (expire && (slots_q != '0)) begin
            slots_d = '0;
            state_d = IDLE;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            slots_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slots_q    <= slots_d;
            overflow_q <= overflow_d;
        end
    end

    assign PS2keycode = slots_q;
    assign overflow   = overflow_q;

endmodule
